// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay frame controller.
// Mode encodings, blank-line marker, scan-line reset row and the plate edge bundle.
package overlay_pkg;

    typedef enum logic [1:0] {
        ModeOff  = 2'd0,
        ModeEdge = 2'd1,
        ModeScan = 2'd2,
        ModeAll  = 2'd3
    } mode_e;

    localparam logic [11:0] NO_LINE    = 12'hFFF;
    localparam logic [11:0] SCAN_RESET = 12'd130;

    typedef struct packed {
        logic [11:0] left;
        logic [11:0] right;
        logic [11:0] up;
        logic [11:0] down;
    } edges_t;

    localparam edges_t EDGES_BLANK = '{left: NO_LINE, right: NO_LINE, up: NO_LINE, down: NO_LINE};

    function automatic mode_e mode_next(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-time counter and press pulse.
// A press is a 1->0 transition of the debounced (active-low) level.
module key_debounce #(
    parameter int unsigned DEB_CNT = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter runs only while the synchronised input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CNT - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_d;
    end

    assign press_o = press_q;

endmodule

// File: rtl/overlay_frame_ctrl.sv
// Frame-synchronous overlay controller: latches plate detections per frame, qualifies the
// recognised digit over several frames, blanks on loss, and handles mode/scan-line keys.
module overlay_frame_ctrl
    import overlay_pkg::*;
#(
    parameter int unsigned DEB_CNT       = 250000,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned LOST_FRAMES   = 8,
    parameter int unsigned SCAN_STEP     = 4,
    parameter int unsigned V_ACT         = 272
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vs,
    input  logic [2:0]  key,
    input  logic        det_valid,
    input  logic [3:0]  det_digit,
    input  logic [11:0] det_left,
    input  logic [11:0] det_right,
    input  logic [11:0] det_up,
    input  logic [11:0] det_down,
    output logic [11:0] o_edge_left,
    output logic [11:0] o_edge_right,
    output logic [11:0] o_edge_up,
    output logic [11:0] o_edge_down,
    output logic [3:0]  o_reco_digital,
    output logic        o_digit_valid,
    output logic [11:0] o_y_scanf,
    output logic        o_scan_en,
    output logic [1:0]  o_mode,
    output logic        o_frame_tick
);

    localparam int unsigned LW = $clog2(LOST_FRAMES + 1);
    localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);

    logic [2:0] press;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_i   (key[i]),
            .press_o (press[i])
        );
    end

    logic          vs_q;
    logic          tick_q, tick_d;
    mode_e         mode_q, mode_d;
    logic [11:0]   scan_pend_q, scan_pend_d;
    logic [11:0]   y_scan_q, y_scan_d;
    edges_t        pend_q, pend_d;
    logic [3:0]    pend_digit_q, pend_digit_d;
    logic          seen_q, seen_d;
    edges_t        edges_q, edges_d;
    logic [3:0]    cand_q, cand_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [LW-1:0] lost_q, lost_d;
    logic [3:0]    reco_q, reco_d;
    logic          dvalid_q, dvalid_d;
    logic [12:0]   scan_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q         <= 1'b0;
            tick_q       <= 1'b0;
            mode_q       <= ModeAll;
            scan_pend_q  <= SCAN_RESET;
            y_scan_q     <= SCAN_RESET;
            pend_q       <= '0;
            pend_digit_q <= '0;
            seen_q       <= 1'b0;
            edges_q      <= EDGES_BLANK;
            cand_q       <= '0;
            stable_q     <= '0;
            lost_q       <= '0;
            reco_q       <= '0;
            dvalid_q     <= 1'b0;
        end else begin
            vs_q         <= i_vs;
            tick_q       <= tick_d;
            mode_q       <= mode_d;
            scan_pend_q  <= scan_pend_d;
            y_scan_q     <= y_scan_d;
            pend_q       <= pend_d;
            pend_digit_q <= pend_digit_d;
            seen_q       <= seen_d;
            edges_q      <= edges_d;
            cand_q       <= cand_d;
            stable_q     <= stable_d;
            lost_q       <= lost_d;
            reco_q       <= reco_d;
            dvalid_q     <= dvalid_d;
        end
    end

    always_comb begin
        tick_d       = i_vs & ~vs_q;
        mode_d       = press[0] ? mode_next(mode_q) : mode_q;
        scan_pend_d  = scan_pend_q;
        y_scan_d     = y_scan_q;
        pend_d       = pend_q;
        pend_digit_d = pend_digit_q;
        seen_d       = seen_q;
        edges_d      = edges_q;
        cand_d       = cand_q;
        stable_d     = stable_q;
        lost_d       = lost_q;
        reco_d       = reco_q;
        dvalid_d     = dvalid_q;
        scan_up      = {1'b0, scan_pend_q} + 13'(SCAN_STEP);

        if (press[2] && !press[1]) begin
            scan_pend_d = (scan_up > 13'(V_ACT - 2)) ? 12'(V_ACT - 2) : scan_up[11:0];
        end else if (press[1] && !press[2]) begin
            scan_pend_d = (scan_pend_q < 12'(SCAN_STEP + 1)) ? 12'd1
                                                              : scan_pend_q - 12'(SCAN_STEP);
        end

        if (tick_q) begin
            y_scan_d = scan_pend_q;
            seen_d   = 1'b0;
            if (seen_q) begin
                lost_d  = '0;
                edges_d = mode_q[0] ? pend_q : EDGES_BLANK;
                if (pend_digit_q == cand_q) begin
                    if (stable_q != SW'(STABLE_FRAMES)) begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    cand_d   = pend_digit_q;
                    stable_d = SW'(1);
                end
                if (stable_d == SW'(STABLE_FRAMES)) begin
                    reco_d   = cand_d;
                    dvalid_d = 1'b1;
                end
            end else begin
                if (lost_q != LW'(LOST_FRAMES)) begin
                    lost_d = lost_q + 1'b1;
                end
                if (lost_d == LW'(LOST_FRAMES)) begin
                    edges_d  = EDGES_BLANK;
                    dvalid_d = 1'b0;
                    stable_d = '0;
                end
            end
            // Edge lines stay blank on every tick while edge overlay is disabled.
            if (!mode_q[0]) begin
                edges_d = EDGES_BLANK;
            end
        end

        // A detection coinciding with the tick becomes pending for the next frame.
        if (det_valid) begin
            pend_d       = '{left: det_left, right: det_right, up: det_up, down: det_down};
            pend_digit_d = det_digit;
            seen_d       = 1'b1;
        end
    end

    assign o_edge_left    = edges_q.left;
    assign o_edge_right   = edges_q.right;
    assign o_edge_up      = edges_q.up;
    assign o_edge_down    = edges_q.down;
    assign o_reco_digital = reco_q;
    assign o_digit_valid  = dvalid_q;
    assign o_y_scanf      = y_scan_q;
    assign o_scan_en      = mode_q[1];
    assign o_mode         = mode_q;
    assign o_frame_tick   = tick_q;

endmodule

// File: tb/tb_overlay_frame_ctrl.sv
// Directed bench for overlay_frame_ctrl with a short debounce time.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_overlay_frame_ctrl;

    localparam int unsigned DEB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_vs;
    logic [2:0]  key;
    logic        det_valid;
    logic [3:0]  det_digit;
    logic [11:0] det_left, det_right, det_up, det_down;
    logic [11:0] o_edge_left, o_edge_right, o_edge_up, o_edge_down;
    logic [3:0]  o_reco_digital;
    logic        o_digit_valid;
    logic [11:0] o_y_scanf;
    logic        o_scan_en;
    logic [1:0]  o_mode;
    logic        o_frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    overlay_frame_ctrl #(
        .DEB_CNT       (DEB),
        .STABLE_FRAMES (3),
        .LOST_FRAMES   (8),
        .SCAN_STEP     (4),
        .V_ACT         (272)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_vs           (i_vs),
        .key            (key),
        .det_valid      (det_valid),
        .det_digit      (det_digit),
        .det_left       (det_left),
        .det_right      (det_right),
        .det_up         (det_up),
        .det_down       (det_down),
        .o_edge_left    (o_edge_left),
        .o_edge_right   (o_edge_right),
        .o_edge_up      (o_edge_up),
        .o_edge_down    (o_edge_down),
        .o_reco_digital (o_reco_digital),
        .o_digit_valid  (o_digit_valid),
        .o_y_scanf      (o_y_scanf),
        .o_scan_en      (o_scan_en),
        .o_mode         (o_mode),
        .o_frame_tick   (o_frame_tick)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_det(input logic [3:0] d, input logic [11:0] l, input logic [11:0] r,
                           input logic [11:0] u, input logic [11:0] dn);
        det_valid = 1'b1;
        det_digit = d;
        det_left  = l;
        det_right = r;
        det_up    = u;
        det_down  = dn;
    endtask

    task automatic det(input logic [3:0] d, input logic [11:0] l, input logic [11:0] r,
                       input logic [11:0] u, input logic [11:0] dn);
        @(negedge clk);
        set_det(d, l, r, u, dn);
        @(negedge clk);
        det_valid = 1'b0;
    endtask

    // Returns after the commit edge that follows the tick cycle.
    task automatic frame();
        @(negedge clk);
        i_vs = 1'b1;
        @(negedge clk);
        i_vs = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] mask);
        @(negedge clk);
        key = key & ~mask;
        repeat (2 * DEB) @(negedge clk);
        key = 3'b111;
        repeat (2 * DEB) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        i_vs = 1'b0;
        key = 3'b111;
        det_valid = 1'b0;
        det_digit = '0;
        det_left = '0;
        det_right = '0;
        det_up = '0;
        det_down = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_edge_left", o_edge_left, 12'hFFF);
        chk("rst_edge_down", o_edge_down, 12'hFFF);
        chk("rst_reco", 12'(o_reco_digital), 12'd0);
        chk("rst_dvalid", 12'(o_digit_valid), 12'd0);
        chk("rst_y_scanf", o_y_scanf, 12'd130);
        chk("rst_mode", 12'(o_mode), 12'd3);
        chk("rst_scan_en", 12'(o_scan_en), 12'd1);
        chk("rst_tick", 12'(o_frame_tick), 12'd0);

        // One-cycle tick after vsync rise
        @(negedge clk);
        i_vs = 1'b1;
        @(negedge clk);
        chk("tick_high", 12'(o_frame_tick), 12'd1);
        @(negedge clk);
        chk("tick_low_vs_held", 12'(o_frame_tick), 12'd0);
        i_vs = 1'b0;
        repeat (3) @(negedge clk);

        // Digit 5 over three frames publishes on the third tick
        det(4'd5, 12'd10, 12'd20, 12'd30, 12'd40);
        frame();
        chk("s1_dvalid", 12'(o_digit_valid), 12'd0);
        chk("s1_edge_left", o_edge_left, 12'd10);
        chk("s1_edge_down", o_edge_down, 12'd40);
        det(4'd5, 12'd10, 12'd20, 12'd30, 12'd40);
        frame();
        chk("s2_dvalid", 12'(o_digit_valid), 12'd0);
        det(4'd5, 12'd10, 12'd20, 12'd30, 12'd40);
        frame();
        chk("s3_dvalid", 12'(o_digit_valid), 12'd1);
        chk("s3_reco", 12'(o_reco_digital), 12'd5);

        // Eight frames without detection blank the overlay on the eighth tick
        repeat (7) frame();
        chk("lost7_edge_left", o_edge_left, 12'd10);
        chk("lost7_dvalid", 12'(o_digit_valid), 12'd1);
        frame();
        chk("lost8_edge_left", o_edge_left, 12'hFFF);
        chk("lost8_edge_right", o_edge_right, 12'hFFF);
        chk("lost8_edge_up", o_edge_up, 12'hFFF);
        chk("lost8_edge_down", o_edge_down, 12'hFFF);
        chk("lost8_dvalid", 12'(o_digit_valid), 12'd0);

        // Digits 5,5,7,7,7: only 7 is published, on the fifth tick
        det(4'd5, 12'd51, 12'd52, 12'd53, 12'd54);
        frame();
        chk("d1_dvalid", 12'(o_digit_valid), 12'd0);
        chk("d1_edge_up", o_edge_up, 12'd53);
        det(4'd5, 12'd51, 12'd52, 12'd53, 12'd54);
        frame();
        chk("d2_dvalid", 12'(o_digit_valid), 12'd0);
        det(4'd7, 12'd61, 12'd62, 12'd63, 12'd64);
        frame();
        chk("d3_dvalid", 12'(o_digit_valid), 12'd0);
        det(4'd7, 12'd61, 12'd62, 12'd63, 12'd64);
        frame();
        chk("d4_dvalid", 12'(o_digit_valid), 12'd0);
        det(4'd7, 12'd61, 12'd62, 12'd63, 12'd64);
        frame();
        chk("d5_dvalid", 12'(o_digit_valid), 12'd1);
        chk("d5_reco", 12'(o_reco_digital), 12'd7);

        // Detection coinciding with the tick waits one frame
        det(4'd7, 12'd100, 12'd101, 12'd102, 12'd103);
        @(negedge clk);
        i_vs = 1'b1;
        @(negedge clk);
        chk("coinc_tick", 12'(o_frame_tick), 12'd1);
        set_det(4'd7, 12'd200, 12'd201, 12'd202, 12'd203);
        i_vs = 1'b0;
        @(negedge clk);
        det_valid = 1'b0;
        chk("coinc_old_left", o_edge_left, 12'd100);
        chk("coinc_old_down", o_edge_down, 12'd103);
        repeat (3) @(negedge clk);
        frame();
        chk("coinc_new_left", o_edge_left, 12'd200);
        chk("coinc_new_down", o_edge_down, 12'd203);

        // Scan line: one press moves the pending row, output follows at the tick
        press(3'b100);
        chk("scan_before_tick", o_y_scanf, 12'd130);
        frame();
        chk("scan_after_tick", o_y_scanf, 12'd134);
        repeat (39) press(3'b100);
        frame();
        chk("scan_sat_high", o_y_scanf, 12'd270);
        press(3'b010);
        frame();
        chk("scan_dec", o_y_scanf, 12'd266);
        press(3'b110);
        frame();
        chk("scan_both_keys", o_y_scanf, 12'd266);
        chk("edges_before_mode", o_edge_left, 12'd200);

        // Short glitch on key[0] is ignored
        @(negedge clk);
        key = 3'b110;
        repeat (DEB / 2) @(negedge clk);
        key = 3'b111;
        repeat (3 * DEB) @(negedge clk);
        chk("glitch_mode", 12'(o_mode), 12'd3);

        press(3'b001);
        chk("mode_p1", 12'(o_mode), 12'd0);
        chk("scan_en_p1", 12'(o_scan_en), 12'd0);
        frame();
        chk("mode_off_blank", o_edge_left, 12'hFFF);
        press(3'b001);
        chk("mode_p2", 12'(o_mode), 12'd1);
        chk("scan_en_p2", 12'(o_scan_en), 12'd0);
        press(3'b001);
        chk("mode_p3", 12'(o_mode), 12'd2);
        chk("scan_en_p3", 12'(o_scan_en), 12'd1);
        press(3'b001);
        chk("mode_p4", 12'(o_mode), 12'd3);
        chk("scan_en_p4", 12'(o_scan_en), 12'd1);

        // Reset mid-frame discards the pending detection
        det(4'd9, 12'd1, 12'd2, 12'd3, 12'd4);
        @(negedge clk);
        key = 3'b011;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        key = 3'b111;
        @(negedge clk);
        chk("mrst_y_scanf", o_y_scanf, 12'd130);
        frame();
        chk("mrst_edge_left", o_edge_left, 12'hFFF);
        chk("mrst_dvalid", 12'(o_digit_valid), 12'd0);
        repeat (3 * DEB) @(negedge clk);
        chk("mrst_scan_pending", o_y_scanf, 12'd130);
        frame();
        chk("mrst_scan_after_tick", o_y_scanf, 12'd130);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
